// File: rtl/fifo_sync_lookahead.sv
// Synchronous first-word-fall-through FIFO exposing the head word and the
// word behind it, with registered occupancy flags and sticky error flags.
//
// Ports:
//   clk          rising-edge clock
//   resn         asynchronous active-low reset
//   shift_in     write strobe, accepted when not full
//   data_in      write data
//   shift_out    pop strobe, accepted when not empty
//   data         head word, mem[rd_ptr]
//   data_next    word behind the head, valid when count >= 2
//   full/empty/almost_full/almost_empty  decoded from the count register
//   count        occupancy 0..DEPTH
//   overflow     sticky: write attempted while full
//   underflow    sticky: pop attempted while empty
//   clear_err    synchronous clear of overflow/underflow
module fifo_sync_lookahead #(
    parameter int WIDTH    = 8,
    parameter int DEPTH    = 16,
    parameter int AF_LEVEL = DEPTH - 2,
    parameter int AE_LEVEL = 2
) (
    input  logic                     clk,
    input  logic                     resn,
    input  logic                     shift_in,
    input  logic [WIDTH-1:0]         data_in,
    input  logic                     shift_out,
    output logic [WIDTH-1:0]         data,
    output logic [WIDTH-1:0]         data_next,
    output logic                     full,
    output logic                     empty,
    output logic                     almost_full,
    output logic                     almost_empty,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     overflow,
    output logic                     underflow,
    input  logic                     clear_err
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    localparam logic [CW-1:0] CNT_FULL = CW'(DEPTH);
    localparam logic [CW-1:0] CNT_AF   = CW'(AF_LEVEL);
    localparam logic [CW-1:0] CNT_AE   = CW'(AE_LEVEL);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW-1:0]    rd_nxt;
    logic [CW-1:0]    cnt;
    logic             wr_en;
    logic             rd_en;

    // Flags depend only on the count register, so strobes reach them
    // one edge later and never combinationally.
    assign full         = (cnt == CNT_FULL);
    assign empty        = (cnt == '0);
    assign almost_full  = (cnt >= CNT_AF);
    assign almost_empty = (cnt <= CNT_AE);
    assign count        = cnt;

    assign wr_en = shift_in  & ~full;
    assign rd_en = shift_out & ~empty;

    assign rd_nxt    = rd_ptr + AW'(1);
    assign data      = mem[rd_ptr];
    assign data_next = mem[rd_nxt];

    // Storage is intentionally not reset; pointers define validity.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_ptr] <= data_in;
        end
    end

    always_ff @(posedge clk or negedge resn) begin
        if (!resn) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            cnt       <= '0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            if (wr_en) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (rd_en) begin
                rd_ptr <= rd_nxt;
            end
            unique case ({wr_en, rd_en})
                2'b10:   cnt <= cnt + CW'(1);
                2'b01:   cnt <= cnt - CW'(1);
                default: cnt <= cnt;
            endcase
            // A new error wins over a simultaneous clear.
            overflow  <= (overflow  & ~clear_err) | (shift_in  & full);
            underflow <= (underflow & ~clear_err) | (shift_out & empty);
        end
    end

endmodule

// File: tb/tb_fifo_sync_lookahead.sv
// Self-checking bench for fifo_sync_lookahead: directed scenarios plus
// randomized traffic compared against a queue-based reference model.
module tb_fifo_sync_lookahead;

    localparam int WIDTH = 8;
    localparam int DEPTH = 16;
    localparam int AF    = DEPTH - 2;
    localparam int AE    = 2;

    logic             clk;
    logic             resn;
    logic             shift_in;
    logic [WIDTH-1:0] data_in;
    logic             shift_out;
    logic [WIDTH-1:0] data;
    logic [WIDTH-1:0] data_next;
    logic             full;
    logic             empty;
    logic             almost_full;
    logic             almost_empty;
    logic [4:0]       count;
    logic             overflow;
    logic             underflow;
    logic             clear_err;

    fifo_sync_lookahead #(
        .WIDTH(WIDTH),
        .DEPTH(DEPTH)
    ) dut (
        .clk         (clk),
        .resn        (resn),
        .shift_in    (shift_in),
        .data_in     (data_in),
        .shift_out   (shift_out),
        .data        (data),
        .data_next   (data_next),
        .full        (full),
        .empty       (empty),
        .almost_full (almost_full),
        .almost_empty(almost_empty),
        .count       (count),
        .overflow    (overflow),
        .underflow   (underflow),
        .clear_err   (clear_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_pass = 0;

    logic [WIDTH-1:0] q[$];
    bit               m_ovf;
    bit               m_unf;

    task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
        n_chk++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic compare_all(string tag);
        int n;
        n = q.size();
        check({tag, ".count"}, 32'(count), 32'(n));
        check({tag, ".empty"}, 32'(empty), 32'(n == 0));
        check({tag, ".full"}, 32'(full), 32'(n == DEPTH));
        check({tag, ".af"}, 32'(almost_full), 32'(n >= AF));
        check({tag, ".ae"}, 32'(almost_empty), 32'(n <= AE));
        check({tag, ".ovf"}, 32'(overflow), 32'(m_ovf));
        check({tag, ".unf"}, 32'(underflow), 32'(m_unf));
        if (n >= 1) check({tag, ".data"}, 32'(data), 32'(q[0]));
        if (n >= 2) check({tag, ".next"}, 32'(data_next), 32'(q[1]));
    endtask

    // Drive one cycle of strobes, advance the model by the FIFO rules,
    // then compare just after the clock edge.
    task automatic step(string tag, bit si, logic [WIDTH-1:0] di,
                        bit so, bit ce);
        bit is_full;
        bit is_empty;
        shift_in  = si;
        data_in   = di;
        shift_out = so;
        clear_err = ce;
        is_full   = (q.size() == DEPTH);
        is_empty  = (q.size() == 0);
        m_ovf = (m_ovf && !ce) || (si && is_full);
        m_unf = (m_unf && !ce) || (so && is_empty);
        @(posedge clk);
        #1;
        if (so && !is_empty) void'(q.pop_front());
        if (si && !is_full) q.push_back(di);
        shift_in  = 1'b0;
        shift_out = 1'b0;
        clear_err = 1'b0;
        compare_all(tag);
    endtask

    task automatic do_reset(string tag);
        shift_in  = 1'b0;
        shift_out = 1'b0;
        clear_err = 1'b0;
        data_in   = '0;
        #2;
        resn = 1'b0;
        q.delete();
        m_ovf = 0;
        m_unf = 0;
        #1;
        compare_all(tag);
        @(posedge clk);
        @(negedge clk);
        resn = 1'b1;
    endtask

    initial begin
        resn = 1'b0;
        shift_in = 1'b0;
        shift_out = 1'b0;
        clear_err = 1'b0;
        data_in = '0;
        m_ovf = 0;
        m_unf = 0;

        do_reset("rst");

        step("wr_a5", 1, 8'hA5, 0, 0);

        do_reset("rst2");
        for (int i = 0; i < DEPTH; i++) begin
            step("fill", 1, 8'(i), 0, 0);
        end
        step("wr_ovf", 1, 8'hFF, 0, 0);
        check("head0", 32'(data), 32'h00);
        step("full_rw", 1, 8'h55, 1, 0);
        check("cnt15", 32'(count), 32'd15);
        step("clr", 0, 8'h00, 0, 1);
        check("ovf_clr", 32'(overflow), 32'd0);

        do_reset("rst3");
        step("p10", 1, 8'h10, 0, 0);
        step("p11", 1, 8'h11, 0, 0);
        step("p12", 1, 8'h12, 0, 0);
        for (int i = 0; i < 20; i++) begin
            step("stream", 1, 8'(8'h13 + i), 1, 0);
        end

        do_reset("rst4");
        step("unf", 0, 8'h00, 1, 0);
        step("unf_wr", 1, 8'h7E, 1, 0);
        check("data7e", 32'(data), 32'h7E);

        for (int i = 0; i < 8; i++) begin
            step("nine", 1, 8'(8'h40 + i), 0, 0);
        end
        check("cnt9", 32'(count), 32'd9);
        do_reset("async");
        step("wr_3c", 1, 8'h3C, 0, 0);

        for (int i = 0; i < 1500; i++) begin
            int wp;
            wp = ((i / 150) % 2 == 0) ? 75 : 25;
            step("rand",
                 $urandom_range(0, 99) < wp,
                 8'($urandom),
                 $urandom_range(0, 99) < 100 - wp,
                 $urandom_range(0, 99) < 5);
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1);
    end

endmodule

// File: doc/fifo_sync_lookahead.md
FIFO_SYNC_LOOKAHEAD -- requirements
Module: fifo_sync_lookahead

Interface
REQ-001 The module SHALL have parameter WIDTH, default 8, meaning data word width in bits.
REQ-002 The module SHALL have parameter DEPTH, default 16, meaning storage depth in words; it must be a power of two and at least 4.
REQ-003 The module SHALL have parameter AF_LEVEL, default DEPTH-2, meaning the occupancy at or above which almost_full asserts.
REQ-004 The module SHALL have parameter AE_LEVEL, default 2, meaning the occupancy at or below which almost_empty asserts.
REQ-005 The module SHALL have port clk, input, width 1, the single clock; all logic is rising-edge.
REQ-006 The module SHALL have port resn, input, width 1, the reset: asynchronous assert, active-low.
REQ-007 The module SHALL have port shift_in, input, width 1, the write strobe.
REQ-008 The module SHALL have port data_in, input, width WIDTH, the write data.
REQ-009 The module SHALL have port shift_out, input, width 1, the read/pop strobe.
REQ-010 The module SHALL have port data, output, width WIDTH, the head word (first-word-fall-through).
REQ-011 The module SHALL have port data_next, output, width WIDTH, the word behind the head.
REQ-012 The module SHALL have ports full, empty, almost_full and almost_empty, each an output of width 1, the occupancy flags.
REQ-013 The module SHALL have port count, output, width $clog2(DEPTH)+1, the current occupancy, 0..DEPTH.
REQ-014 The module SHALL have ports overflow and underflow, each an output of width 1, sticky error flags.
REQ-015 The module SHALL have port clear_err, input, width 1, a synchronous clear for overflow and underflow.

Function
REQ-016 Storage SHALL be a DEPTH x WIDTH array with a write pointer and a read pointer, each $clog2(DEPTH) bits wide and wrapping modulo DEPTH; count SHALL be held in a separate register.
REQ-017 A write SHALL be accepted when shift_in=1 and full=0: data_in is stored at wr_ptr and wr_ptr increments on the same edge.
REQ-018 A pop SHALL be accepted when shift_out=1 and empty=0: rd_ptr increments on that edge.
REQ-019 Count update: write-only adds 1; pop-only subtracts 1; write and pop accepted together leave count unchanged.
REQ-020 Full (count=DEPTH): shift_in SHALL be ignored even if shift_out=1 in the same cycle, the pop still proceeds, and overflow is set if shift_in=1.
REQ-021 Empty (count=0): shift_out SHALL be ignored and underflow is set; a simultaneous shift_in is still accepted.
REQ-022 data SHALL equal mem[rd_ptr] combinationally from registered pointers, and a written word SHALL appear on data the cycle after the write edge when the FIFO was empty.
REQ-023 data_next SHALL equal mem[rd_ptr+1 mod DEPTH] and is valid only when count>=2; its value is don't-care otherwise.
REQ-024 Flags SHALL be decoded from the count register: full=(count==DEPTH), empty=(count==0), almost_full=(count>=AF_LEVEL), almost_empty=(count<=AE_LEVEL).
REQ-025 Flag latency SHALL be exactly one clock after the accepting edge, with no combinational path from strobes to flags.
REQ-026 overflow and underflow SHALL stay set until clear_err=1 at a clock edge; if clear_err and a new error coincide, the flag SHALL remain set.
REQ-027 The design SHALL contain no state machine beyond the pointers and count, and SHALL support full throughput of one write and one pop per cycle indefinitely.

Reset
REQ-028 When resn=0, the module SHALL asynchronously clear wr_ptr, rd_ptr, count, overflow and underflow; empty=1, almost_empty=1, full=0, almost_full=0.
REQ-029 Memory contents SHALL NOT be reset, and data and data_next are don't-care while empty.
REQ-030 The module SHALL leave reset on the first rising clk edge after resn goes 1, with no strobe accepted on the release edge while resn is still low.
REQ-031 A reset asserted mid-burst SHALL discard all stored words, and the next write after release SHALL appear on data.

Verification (DEPTH=16, WIDTH=8, defaults)
REQ-032 Reset then write 0xA5 -> next cycle empty=0, data=0xA5, count=1, almost_empty=1.
REQ-033 Write 0x00..0x0F back-to-back -> after the 16th edge full=1, almost_full has been 1 since count=14; a 17th write 0xFF is dropped, overflow=1, and the head remains 0x00.
REQ-034 At full, assert shift_in and shift_out together with data_in=0x55 -> pop occurs, write dropped, count=15, overflow=1; clear_err -> overflow=0.
REQ-035 At count=3 holding 0x10,0x11,0x12, assert write 0x13 and pop together for 20 cycles -> count stays 3, and data/data_next track sequentially across pointer wrap.
REQ-036 Pop when empty -> underflow=1 and count stays 0; simultaneous pop plus write 0x7E when empty -> count=1, data=0x7E, underflow=1.
REQ-037 Assert resn=0 asynchronously mid-cycle at count=9 -> flags reset immediately with no clock edge; after release, write 0x3C -> data=0x3C, count=1.
